// File: rtl/pkt_ser_pkg.sv
// Shared types and constants for the packet bit serializer.
//   state_e       : framing FSM states
//   PREAMBLE_BYTE : byte repeated during the preamble field
//   SFD_BYTE      : start-of-frame delimiter
//   CRC8_POLY     : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
package pkt_ser_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPreamble = 3'd1,
    StSfd      = 3'd2,
    StPayload  = 3'd3,
    StCrc      = 3'd4,
    StFinish   = 3'd5
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

endpackage

// File: rtl/crc8_byte.sv
// Combinational CRC-8 update over one byte, MSB first.
// Polynomial CRC8_POLY, no reflection, no final XOR.
//   crc_i  : running CRC before this byte
//   data_i : byte being absorbed
//   crc_o  : running CRC after this byte
module crc8_byte
  import pkt_ser_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] acc;

  always_comb begin
    acc = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      acc = acc[7] ? ((acc << 1) ^ CRC8_POLY) : (acc << 1);
    end
    crc_o = acc;
  end

endmodule

// File: rtl/pkt_bit_serializer.sv
// Packet bit serializer: on a rising edge of fifo_full (while idle) emits
// PREAMBLE_BYTES x 0x55, 0xD5, then pkt_len payload bytes popped from the fifo,
// MSB first, each bit lasting CLKS_PER_BIT clocks with no gaps.
// Optional build macro CRC8_EN appends a CRC-8 byte over the payload.
//   clk, reset_n : clock, asynchronous active-low reset
//   fifo_full    : rising edge starts a packet
//   pkt_len      : payload byte count, latched at start
//   fifo_rd_en   : one-cycle pop request; fifo_data valid the next cycle
//   fifo_data    : fifo read data
//   abort        : synchronous abort, returns to idle without tx_done
//   tx_bit       : serial data
//   tx_bit_stb   : first cycle of each bit period
//   tx_active    : packet bits are being transmitted
//   tx_done      : one-cycle pulse after the last bit of a normal packet
module pkt_bit_serializer
  import pkt_ser_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 4,
  parameter int unsigned PREAMBLE_BYTES = 2,
  parameter int unsigned DATA_W         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_full,
  input  logic [7:0]        pkt_len,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              abort,
  output logic              tx_bit,
  output logic              tx_bit_stb,
  output logic              tx_active,
  output logic              tx_done
);

  localparam logic [7:0] ClkLast = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] PreLast = 8'(PREAMBLE_BYTES - 1);

  state_e            state_q, state_d;
  logic              fifo_full_q;
  logic [7:0]        len_q, len_d;
  logic [7:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] next_q, next_d;
  logic              rd_pend_q;

  logic              start;
  logic              in_bits;
  logic              bit_end;
  logic              byte_end;
  logic              pop_slot;
  logic [DATA_W-1:0] load_byte;
  state_e            tail_state;
  logic [DATA_W-1:0] tail_byte;

`ifdef CRC8_EN
  logic [7:0] crc_q, crc_d, crc_nxt;

  crc8_byte u_crc8_byte (
    .crc_i  (crc_q),
    .data_i (load_byte),
    .crc_o  (crc_nxt)
  );

  assign tail_state = StCrc;
  assign tail_byte  = crc_q;
`else
  assign tail_state = StFinish;
  assign tail_byte  = '0;
`endif

  // Abort takes priority over a coincident start.
  assign start    = fifo_full && !fifo_full_q && !abort;
  assign in_bits  = (state_q == StPreamble) || (state_q == StSfd) ||
                    (state_q == StPayload)  || (state_q == StCrc);
  assign bit_end  = (clk_cnt_q == ClkLast);
  assign byte_end = bit_end && (bit_cnt_q == 3'd7);

  // When CLKS_PER_BIT is 2 the popped byte arrives in the same cycle it must
  // be loaded, so bypass the next-byte register.
  assign load_byte = rd_pend_q ? fifo_data : next_q;
  assign next_d    = load_byte;

  // Prefetch during the LSB period of the SFD and of every payload byte
  // except the last one.
  assign pop_slot = ((state_q == StSfd) && (len_q != 8'd0)) ||
                    ((state_q == StPayload) && (byte_cnt_q > 8'd1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
`ifdef CRC8_EN
    crc_d      = crc_q;
`endif

    // Bit timer and shifter run in every bit-emitting state.
    if (in_bits) begin
      if (bit_end) begin
        clk_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
      end else begin
        clk_cnt_d = clk_cnt_q + 8'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StPreamble;
          len_d      = pkt_len;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = PREAMBLE_BYTE;
`ifdef CRC8_EN
          crc_d      = '0;
`endif
        end
      end
      StPreamble: begin
        if (byte_end) begin
          if (byte_cnt_q == PreLast) begin
            state_d = StSfd;
            shift_d = SFD_BYTE;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
            shift_d    = PREAMBLE_BYTE;
          end
        end
      end
      StSfd: begin
        if (byte_end) begin
          if (len_q == 8'd0) begin
            state_d = tail_state;
            shift_d = tail_byte;
          end else begin
            state_d    = StPayload;
            byte_cnt_d = len_q;
            shift_d    = load_byte;
`ifdef CRC8_EN
            crc_d      = crc_nxt;
`endif
          end
        end
      end
      StPayload: begin
        if (byte_end) begin
          if (byte_cnt_q == 8'd1) begin
            state_d = tail_state;
            shift_d = tail_byte;
          end else begin
            byte_cnt_d = byte_cnt_q - 8'd1;
            shift_d    = load_byte;
`ifdef CRC8_EN
            crc_d      = crc_nxt;
`endif
          end
        end
      end
`ifdef CRC8_EN
      StCrc: begin
        if (byte_end) begin
          state_d = StFinish;
          shift_d = '0;
        end
      end
`endif
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      fifo_full_q <= 1'b0;
      len_q       <= '0;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      next_q      <= '0;
      rd_pend_q   <= 1'b0;
`ifdef CRC8_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fifo_full_q <= fifo_full;
      len_q       <= len_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      next_q      <= next_d;
      rd_pend_q   <= fifo_rd_en;
`ifdef CRC8_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign tx_active  = in_bits;
  assign tx_bit     = in_bits && shift_q[DATA_W-1];
  assign tx_bit_stb = in_bits && (clk_cnt_q == 8'd0);
  assign tx_done    = (state_q == StFinish);
  assign fifo_rd_en = pop_slot && (bit_cnt_q == 3'd7) && (clk_cnt_q == 8'd0);

endmodule
